// File: rtl/drive_input_controller.sv
// Driver-input front end: debounces the P/R/N/D buttons, classifies brake pedal
// level with hysteresis and runs the speed-aware shift-interlock gear FSM.
module drive_input_controller #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int BRAKE_ON_TH    = 40,
    parameter int BRAKE_HARD_TH  = 160,
    parameter int BRAKE_HYST     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       engine_on,
    input  logic       tick_sample,
    input  logic       btn_p,
    input  logic       btn_r,
    input  logic       btn_n,
    input  logic       btn_d,
    input  logic [7:0] adc_brake,
    input  logic [7:0] speed,
    output logic [3:0] current_gear,
    output logic       is_brake_normal,
    output logic       is_brake_hard,
    output logic       gear_changed,
    output logic       shift_reject
);

    localparam logic [3:0] GEAR_P = 4'd3;
    localparam logic [3:0] GEAR_R = 4'd6;
    localparam logic [3:0] GEAR_N = 4'd9;
    localparam logic [3:0] GEAR_D = 4'd12;

    localparam logic [3:0] DB_LIMIT     = 4'(DEBOUNCE_TICKS);
    localparam logic [7:0] ON_TH        = 8'(BRAKE_ON_TH);
    localparam logic [7:0] HARD_TH      = 8'(BRAKE_HARD_TH);
    localparam logic [7:0] OFF_TH       = 8'(BRAKE_ON_TH - BRAKE_HYST);
    localparam logic [7:0] HARD_EXIT_TH = 8'(BRAKE_HARD_TH - BRAKE_HYST);

    typedef enum logic [1:0] {B_OFF = 2'd0, B_NORMAL = 2'd1, B_HARD = 2'd2} brake_t;

    // Bit 3 = P (highest priority) down to bit 0 = D.
    logic [3:0] raw;
    logic [3:0] deb_r;
    logic [3:0] deb_next;
    logic [3:0] cnt_r [4];
    logic [3:0] cnt_next [4];
    logic [3:0] rise;
    logic       req_valid;
    logic [3:0] req_gear;

    brake_t     brake_r;
    brake_t     brake_next;

    logic [3:0] gear_r;
    logic [3:0] gear_next;
    logic       accept;
    logic       reject;
    logic       changed_r;
    logic       reject_r;

    assign raw = {btn_p, btn_r, btn_n, btn_d};

    // Debounce next-state: counter runs while raw disagrees with the debounced level.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_next[i] = deb_r[i];
            cnt_next[i] = cnt_r[i];
            if (tick_sample) begin
                if (raw[i] == deb_r[i]) begin
                    cnt_next[i] = 4'd0;
                end else if (cnt_r[i] + 4'd1 == DB_LIMIT) begin
                    deb_next[i] = raw[i];
                    cnt_next[i] = 4'd0;
                end else begin
                    cnt_next[i] = cnt_r[i] + 4'd1;
                end
            end else begin
                cnt_next[i] = cnt_r[i];
            end
        end
    end

    assign rise = deb_next & ~deb_r;

    // Priority arbitration; lower-priority simultaneous requests are dropped.
    always_comb begin
        req_valid = 1'b1;
        req_gear  = GEAR_P;
        if (rise[3]) begin
            req_gear = GEAR_P;
        end else if (rise[2]) begin
            req_gear = GEAR_R;
        end else if (rise[1]) begin
            req_gear = GEAR_N;
        end else if (rise[0]) begin
            req_gear = GEAR_D;
        end else begin
            req_valid = 1'b0;
        end
    end

    // Brake classification next-state with release hysteresis.
    always_comb begin
        brake_next = brake_r;
        if (tick_sample) begin
            case (brake_r)
                B_OFF: begin
                    if (adc_brake >= HARD_TH)    brake_next = B_HARD;
                    else if (adc_brake >= ON_TH) brake_next = B_NORMAL;
                    else                         brake_next = B_OFF;
                end
                B_NORMAL: begin
                    if (adc_brake >= HARD_TH)     brake_next = B_HARD;
                    else if (adc_brake < OFF_TH)  brake_next = B_OFF;
                    else                          brake_next = B_NORMAL;
                end
                B_HARD: begin
                    if (adc_brake < OFF_TH)            brake_next = B_OFF;
                    else if (adc_brake < HARD_EXIT_TH) brake_next = B_NORMAL;
                    else                               brake_next = B_HARD;
                end
                default: brake_next = B_OFF;
            endcase
        end else begin
            brake_next = brake_r;
        end
    end

    // Shift interlock: decides accept/reject for the arbitrated request.
    always_comb begin
        gear_next = gear_r;
        accept    = 1'b0;
        reject    = 1'b0;
        if (req_valid && (req_gear != gear_r)) begin
            if (!engine_on && (req_gear != GEAR_P)) begin
                reject = 1'b1;
            end else if ((gear_r == GEAR_P) && (brake_r == B_OFF)) begin
                reject = 1'b1;
            end else if (((req_gear == GEAR_P) || (req_gear == GEAR_R)) && (speed != 8'd0)) begin
                reject = 1'b1;
            end else if ((req_gear == GEAR_D) && (gear_r == GEAR_R) && (speed != 8'd0)) begin
                reject = 1'b1;
            end else begin
                accept    = 1'b1;
                gear_next = req_gear;
            end
        end else begin
            gear_next = gear_r;
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_r     <= 4'd0;
            for (int i = 0; i < 4; i++) cnt_r[i] <= 4'd0;
            brake_r   <= B_OFF;
            gear_r    <= GEAR_P;
            changed_r <= 1'b0;
            reject_r  <= 1'b0;
        end else begin
            deb_r     <= deb_next;
            for (int i = 0; i < 4; i++) cnt_r[i] <= cnt_next[i];
            brake_r   <= brake_next;
            gear_r    <= gear_next;
            changed_r <= accept;
            reject_r  <= reject;
        end
    end

    // Output decode from registered state.
    always_comb begin
        current_gear    = gear_r;
        is_brake_normal = (brake_r == B_NORMAL);
        is_brake_hard   = (brake_r == B_HARD);
        gear_changed    = changed_r;
        shift_reject    = reject_r;
    end

endmodule

// File: tb/tb_drive_input_controller.sv
// Directed self-checking bench for drive_input_controller.
module tb_drive_input_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       engine_on = 1'b0;
    logic       tick_sample = 1'b0;
    logic       btn_p = 1'b0, btn_r = 1'b0, btn_n = 1'b0, btn_d = 1'b0;
    logic [7:0] adc_brake = 8'd0;
    logic [7:0] speed = 8'd0;
    logic [3:0] current_gear;
    logic       is_brake_normal, is_brake_hard, gear_changed, shift_reject;

    int checks = 0;
    int errors = 0;

    drive_input_controller dut (
        .clk(clk), .rst(rst), .engine_on(engine_on), .tick_sample(tick_sample),
        .btn_p(btn_p), .btn_r(btn_r), .btn_n(btn_n), .btn_d(btn_d),
        .adc_brake(adc_brake), .speed(speed), .current_gear(current_gear),
        .is_brake_normal(is_brake_normal), .is_brake_hard(is_brake_hard),
        .gear_changed(gear_changed), .shift_reject(shift_reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic outs(input string tag, input logic [3:0] g, input logic bn, input logic bh,
                        input logic gc, input logic sr);
        check({tag, ".gear"}, {4'd0, current_gear}, {4'd0, g});
        check({tag, ".bn"}, {7'd0, is_brake_normal}, {7'd0, bn});
        check({tag, ".bh"}, {7'd0, is_brake_hard}, {7'd0, bh});
        check({tag, ".gc"}, {7'd0, gear_changed}, {7'd0, gc});
        check({tag, ".sr"}, {7'd0, shift_reject}, {7'd0, sr});
    endtask

    task automatic sample();
        @(negedge clk);
        tick_sample = 1'b1;
        @(posedge clk);
        #1;
        tick_sample = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] v);
        @(negedge clk);
        {btn_p, btn_r, btn_n, btn_d} = v;
    endtask

    task automatic hold(input logic [3:0] v);
        set_btn(v);
        repeat (4) sample();
    endtask

    task automatic release_all();
        set_btn(4'b0000);
        repeat (4) sample();
    endtask

    initial begin
        // Reset state
        @(negedge clk); rst = 1'b1;
        idle(); idle();
        outs("reset", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0;

        // D without brake is rejected on the 4th sample
        engine_on = 1'b1;
        set_btn(4'b0001);
        repeat (3) sample();
        outs("d_nobrake_3", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        outs("d_nobrake_4", 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        check("reject_pulse_end", {7'd0, shift_reject}, 8'd0);
        release_all();
        outs("release_d", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Normal brake, then a bouncing D press
        adc_brake = 8'd100;
        sample();
        outs("brake_100", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        set_btn(4'b0001); sample();
        set_btn(4'b0000); sample();
        set_btn(4'b0001); repeat (3) sample();
        outs("bounce_3stable", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        sample();
        outs("bounce_4stable", 4'd12, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        check("changed_pulse_end", {7'd0, gear_changed}, 8'd0);
        release_all();

        // In D at speed 40
        speed = 8'd40;
        hold(4'b0100);
        outs("d_to_r_moving", 4'd12, 1'b1, 1'b0, 1'b0, 1'b1);
        release_all();
        hold(4'b0010);
        outs("d_to_n_moving", 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        release_all();
        hold(4'b1000);
        outs("n_to_p_moving", 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        release_all();
        speed = 8'd0;
        hold(4'b1000);
        outs("n_to_p_stopped", 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        release_all();

        // Brake sweep with hysteresis
        adc_brake = 8'd0;   sample(); outs("sweep_0",   4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        adc_brake = 8'd170; sample(); outs("sweep_170", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        adc_brake = 8'd155; sample(); outs("sweep_155", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        adc_brake = 8'd150; sample(); outs("sweep_150", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        adc_brake = 8'd35;  sample(); outs("sweep_35",  4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        adc_brake = 8'd31;  sample(); outs("sweep_31",  4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        adc_brake = 8'd40;  sample(); outs("on_th_40",  4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        adc_brake = 8'd160; sample(); outs("hard_th_160", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        adc_brake = 8'd152; sample(); outs("hard_hold_152", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Simultaneous P and D while in N
        adc_brake = 8'd100;
        sample();
        hold(4'b0010);
        outs("p_to_n", 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        release_all();
        speed = 8'd10;
        hold(4'b1001);
        outs("pd_moving", 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        release_all();
        speed = 8'd0;
        hold(4'b1001);
        outs("pd_stopped", 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        release_all();

        // Engine off: leaving P refused
        engine_on = 1'b0;
        hold(4'b0010);
        outs("engine_off_n", 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        release_all();
        engine_on = 1'b1;

        // Reset mid-debounce while in D
        hold(4'b0001);
        outs("p_to_d", 4'd12, 1'b1, 1'b0, 1'b1, 1'b0);
        release_all();
        set_btn(4'b0001);
        repeat (3) sample();
        @(negedge clk); rst = 1'b1;
        idle();
        outs("mid_reset", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0;
        repeat (3) sample();
        outs("post_reset_3", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        sample();
        outs("post_reset_4", 4'd12, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/drive_input_controller.md
Name: drive_input_controller

Overview:
- Driver-input front end that produces the gear and brake signals consumed by the vehicle physics block.
- Debounces the P/R/N/D gear buttons and classifies the raw brake-pedal ADC into normal/hard brake levels with hysteresis.
- Runs a shift-interlock FSM that uses the physics block's speed feedback.
- Sits between the board input pins/ADC and the vehicle physics block. Drives current_gear (P=3, R=6, N=9, D=12), is_brake_normal and is_brake_hard.

Parameters:
- DEBOUNCE_TICKS, 4: number of consecutive tick_sample samples a raw button must hold a new level before the debounced level changes (range 1..15).
- BRAKE_ON_TH, 40: adc_brake level at or above which braking starts.
- BRAKE_HARD_TH, 160: adc_brake level at or above which hard braking starts.
- BRAKE_HYST, 8: hysteresis subtracted from each threshold on release. Constraint: BRAKE_ON_TH > BRAKE_HYST.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- engine_on  in  1  engine running
- tick_sample  in  1  one-cycle sample strobe for debounce and brake evaluation
- btn_p, btn_r, btn_n, btn_d  in  1 each  raw gear buttons, active-high
- adc_brake  in  8  raw brake pedal position
- speed  in  8  vehicle speed feedback, km/h
- current_gear  out  4  3=P, 6=R, 9=N, 12=D
- is_brake_normal  out  1  normal brake level active
- is_brake_hard  out  1  hard brake level active
- gear_changed  out  1  one-cycle pulse when current_gear changes
- shift_reject  out  1  one-cycle pulse when a gear request is refused

Behaviour:
- Reset values (on any rst cycle, including mid-operation):
  - current_gear=3 (P); brake FSM=OFF, so both brake outputs 0.
  - gear_changed=0, shift_reject=0.
  - Debounced button levels=0; debounce counters=0.
- Debounce (per button):
  - Evaluated only on cycles where tick_sample=1.
  - If raw level equals the debounced level, the counter clears. Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_TICKS, the debounced level flips and the counter clears.
  - A 0->1 flip of a debounced level is a request. No request is generated on release.
  - A button held through reset produces a request DEBOUNCE_TICKS samples after reset release.
- Request arbitration:
  - If several requests arise on the same sample, only the highest priority is processed: P > R > N > D. The others are dropped silently.
- Gear FSM (states P, R, N, D), evaluated on the same edge the request is generated:
  - Request equal to current gear: no-op, no pulse.
  - engine_on=0: every request except P is rejected.
  - Leaving P (to R, N or D) requires is_brake_normal|is_brake_hard=1 (brake state as registered before this edge); otherwise reject.
  - Entering P or R requires speed==0; otherwise reject.
  - D from R requires speed==0; otherwise reject.
  - N is accepted from R or D at any speed. D from N is accepted at any speed.
  - Accept: current_gear updates and gear_changed=1 for exactly that cycle.
  - Reject: gear holds and shift_reject=1 for exactly that cycle.
  - Latency: outputs are registered one clk after the tick_sample cycle that completes debounce.
- Brake FSM (OFF, NORMAL, HARD), transitions evaluated only on tick_sample cycles:
  - OFF: adc>=BRAKE_HARD_TH -> HARD; else adc>=BRAKE_ON_TH -> NORMAL.
  - NORMAL: adc>=BRAKE_HARD_TH -> HARD; adc<BRAKE_ON_TH-BRAKE_HYST -> OFF.
  - HARD: adc<BRAKE_ON_TH-BRAKE_HYST -> OFF; else adc<BRAKE_HARD_TH-BRAKE_HYST -> NORMAL.
  - Outputs are registered from state: is_brake_normal=(NORMAL), is_brake_hard=(HARD). They are never both 1.
  - Brake is independent of engine_on.
- Arithmetic:
  - Threshold subtractions are 8-bit unsigned on parameters only; no wrap, guaranteed by the parameter constraint.
  - speed is compared only against zero.
- tick_sample held high for several cycles: each cycle counts as one sample.

Test Plan:
- Reset, then btn_d=1 held for 4 samples with adc_brake=0, engine_on=1 -> shift_reject pulse 1 cycle after the 4th sample; current_gear stays 3.
- adc_brake=100 for one sample (-> is_brake_normal=1), then btn_d held 4 samples -> gear_changed pulse; current_gear=12. Button bouncing 1,0,1,1,1,1 -> request only after the 4 stable ones.
- In D with speed=40: btn_r -> reject, gear stays 12. btn_n -> gear 9. btn_p -> reject. Then speed=0, btn_p -> gear 3.
- adc_brake sweep 0->170->155->150->35->31 on successive samples -> brake state OFF->HARD->HARD->NORMAL->NORMAL->OFF.
- btn_p and btn_d rising together while in N -> only P processed: speed=0 gives gear 3; speed=10 gives reject and no D shift. engine_on=0 with btn_n from P -> reject.
- rst asserted mid-debounce (counter at 3) while in D -> gear 3, brake OFF, pulses 0. Button still held -> fresh request after 4 further samples.
